// File: rtl/cmd_gather_frm.sv
// cmd_gather_frm: collects UART bytes into CMD_BYTES-wide command words.
// A frame may begin with a sync byte and end with an XOR checksum byte. A
// partial frame is dropped after TIMEOUT_TICKS baud ticks with no byte. Good
// commands go to cmd_fifo. Framing, checksum, timeout and drop errors are
// counted in saturating counters.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   baud_tick         one pulse per bit period; time base for the timeout
//   rx_valid/rx_data  received byte strobe and value
//   rx_frame_err      uart_rx stop-bit error pulse; no byte is delivered
//   cmd_fifo_full     cmd_fifo cannot accept a write this cycle
//   cmd_fifo_wr_en    one-cycle write strobe
//   cmd_fifo_wr_data  command word, data byte 0 in the MSBs
//   busy              a frame is in progress
//   *_cnt             saturating error counters
module cmd_gather_frm #(
  parameter int unsigned CMD_BYTES     = 4,
  parameter bit          SYNC_EN       = 1'b1,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter bit          CHKSUM_EN     = 1'b1,
  parameter int unsigned TIMEOUT_TICKS = 20,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   baud_tick,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_frame_err,
  input  logic                   cmd_fifo_full,
  output logic                   cmd_fifo_wr_en,
  output logic [8*CMD_BYTES-1:0] cmd_fifo_wr_data,
  output logic                   busy,
  output logic [CNT_W-1:0]       chk_err_cnt,
  output logic [CNT_W-1:0]       timeout_cnt,
  output logic [CNT_W-1:0]       frame_err_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int unsigned W      = 8 * CMD_BYTES;
  localparam int unsigned IDX_W  = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int unsigned TICK_W = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CMD_BYTES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          acc_q, acc_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [W-1:0]        data_q, data_d;
  logic [W-1:0]        wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic [CNT_W-1:0]    chk_q, tmo_q, fe_q, drop_q;

  logic [W-1:0]        shifted;
  logic [W-1:0]        commit_word;
  logic                commit;
  logic                chk_inc, tmo_inc, fe_inc, drop_inc;

  // The new byte shifts in at the LSB end, so byte 0 ends up in the MSBs
  assign shifted = W'({data_q, rx_data});

  // Next-state, datapath and error-event logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    tick_d      = tick_q;
    data_d      = data_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    commit      = 1'b0;
    commit_word = shifted;
    chk_inc     = 1'b0;
    tmo_inc     = 1'b0;
    fe_inc      = 1'b0;
    drop_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (rx_valid && !rx_frame_err) begin
          if (SYNC_EN) begin
            if (rx_data == SYNC_BYTE) begin
              state_d = ST_COLLECT;
              idx_d   = '0;
              acc_d   = '0;
            end
          end else begin
            data_d = shifted;
            acc_d  = rx_data;
            idx_d  = IDX_W'(1);
            if (CMD_BYTES == 1) begin
              if (CHKSUM_EN) state_d = ST_CHECK;
              else           commit  = 1'b1;
            end else begin
              state_d = ST_COLLECT;
            end
          end
        end
      end

      ST_COLLECT: begin
        if (rx_frame_err) begin
          fe_inc  = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          data_d = shifted;
          acc_d  = acc_q ^ rx_data;
          idx_d  = idx_q + IDX_W'(1);
          tick_d = '0;
          if (idx_q == LAST_IDX) begin
            if (CHKSUM_EN) state_d = ST_CHECK;
            else           commit  = 1'b1;
          end
        end else if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            tmo_inc = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      ST_CHECK: begin
        if (rx_frame_err) begin
          fe_inc  = 1'b1;
          state_d = ST_IDLE;
        end else if (rx_valid) begin
          state_d = ST_IDLE;
          if (rx_data == acc_q) begin
            commit      = 1'b1;
            commit_word = data_q;
          end else begin
            chk_inc = 1'b1;
          end
        end else if (baud_tick) begin
          if (tick_q == TICK_LAST) begin
            tmo_inc = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The word is latched even on a drop; only the strobe is withheld
    if (commit) begin
      state_d   = ST_IDLE;
      wr_data_d = commit_word;
      if (cmd_fifo_full) drop_inc = 1'b1;
      else               wr_en_d  = 1'b1;
    end

    if (state_d == ST_IDLE) begin
      tick_d = '0;
      idx_d  = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      tick_q    <= '0;
      data_q    <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      tick_q    <= tick_d;
      data_q    <= data_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

  // Saturating error counters
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q  <= '0;
      tmo_q  <= '0;
      fe_q   <= '0;
      drop_q <= '0;
    end else begin
      if (chk_inc  && (chk_q  != '1)) chk_q  <= chk_q  + CNT_W'(1);
      if (tmo_inc  && (tmo_q  != '1)) tmo_q  <= tmo_q  + CNT_W'(1);
      if (fe_inc   && (fe_q   != '1)) fe_q   <= fe_q   + CNT_W'(1);
      if (drop_inc && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign cmd_fifo_wr_en   = wr_en_q;
  assign cmd_fifo_wr_data = wr_data_q;
  assign busy             = (state_q != ST_IDLE);
  assign chk_err_cnt      = chk_q;
  assign timeout_cnt      = tmo_q;
  assign frame_err_cnt    = fe_q;
  assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_cmd_gather_frm.sv
// Bench for cmd_gather_frm: a directed vector table, hand sequences and
// random frames for the default configuration, checked against a queue-based
// frame model. A second instance covers the 2-byte, no-sync, no-checksum
// configuration.
module tb_cmd_gather_frm;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        rst_a, bt_a, v_a, fe_a, full_a;
  logic [7:0]  d_a;
  logic        wr_a, busy_a;
  logic [31:0] wd_a;
  logic [7:0]  chk_a, tmo_a, fec_a, drop_a;

  cmd_gather_frm dut_a (
    .clk(clk), .rst(rst_a), .baud_tick(bt_a), .rx_valid(v_a), .rx_data(d_a),
    .rx_frame_err(fe_a), .cmd_fifo_full(full_a), .cmd_fifo_wr_en(wr_a),
    .cmd_fifo_wr_data(wd_a), .busy(busy_a), .chk_err_cnt(chk_a),
    .timeout_cnt(tmo_a), .frame_err_cnt(fec_a), .drop_cnt(drop_a)
  );

  // Instance B: 2 data bytes, no sync, no checksum
  logic        rst_b, bt_b, v_b, fe_b, full_b;
  logic [7:0]  d_b;
  logic        wr_b, busy_b;
  logic [15:0] wd_b;
  logic [7:0]  chk_b, tmo_b, fec_b, drop_b;

  cmd_gather_frm #(.CMD_BYTES(2), .SYNC_EN(1'b0), .CHKSUM_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .baud_tick(bt_b), .rx_valid(v_b), .rx_data(d_b),
    .rx_frame_err(fe_b), .cmd_fifo_full(full_b), .cmd_fifo_wr_en(wr_b),
    .cmd_fifo_wr_data(wd_b), .busy(busy_b), .chk_err_cnt(chk_b),
    .timeout_cnt(tmo_b), .frame_err_cnt(fec_b), .drop_cnt(drop_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame model for instance A: bytes of the current frame held in a queue
  logic        m_in;
  logic [7:0]  m_q[$];
  int          m_ticks, m_chk, m_tmo, m_fe, m_drop;
  logic        m_wr;
  logic [31:0] m_data;

  function automatic int sat(input int x);
    return (x < 255) ? x + 1 : x;
  endfunction

  function automatic void model_reset();
    m_in = 1'b0; m_q.delete(); m_ticks = 0;
    m_chk = 0; m_tmo = 0; m_fe = 0; m_drop = 0;
    m_wr = 1'b0; m_data = 32'h0;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d,
                                     input logic fe, input logic bt, input logic full);
    logic [7:0] x;
    m_wr = 1'b0;
    if (!m_in) begin
      if (v && !fe && d == 8'hA5) begin
        m_in = 1'b1; m_q.delete(); m_ticks = 0;
      end
    end else if (fe) begin
      m_fe = sat(m_fe); m_in = 1'b0;
    end else if (v) begin
      m_q.push_back(d);
      m_ticks = 0;
      if (m_q.size() == 5) begin
        x = 8'h00;
        for (int i = 0; i < 4; i++) x = x ^ m_q[i];
        if (x == m_q[4]) begin
          m_data = {m_q[0], m_q[1], m_q[2], m_q[3]};
          if (full) m_drop = sat(m_drop);
          else      m_wr = 1'b1;
        end else begin
          m_chk = sat(m_chk);
        end
        m_in = 1'b0;
      end
    end else if (bt) begin
      m_ticks++;
      if (m_ticks == 20) begin
        m_tmo = sat(m_tmo); m_in = 1'b0;
      end
    end
  endfunction

  task automatic apply_a(input logic v, input logic [7:0] d, input logic fe,
                         input logic bt, input logic full);
    v_a = v; d_a = d; fe_a = fe; bt_a = bt; full_a = full;
    @(posedge clk);
    model_step(v, d, fe, bt, full);
    #1;
    v_a = 1'b0; d_a = 8'h00; fe_a = 1'b0; bt_a = 1'b0; full_a = 1'b0;
  endtask

  task automatic check_model();
    check("model_wr_en", 32'(wr_a), 32'(m_wr));
    if (m_wr) check("model_wr_data", wd_a, m_data);
    check("model_busy", 32'(busy_a), 32'(m_in));
    check("model_chk_cnt", 32'(chk_a), 32'(m_chk));
    check("model_tmo_cnt", 32'(tmo_a), 32'(m_tmo));
    check("model_fe_cnt", 32'(fec_a), 32'(m_fe));
    check("model_drop_cnt", 32'(drop_a), 32'(m_drop));
  endtask

  task automatic apply_b(input logic v, input logic [7:0] d, input logic r);
    v_b = v; d_b = d; rst_b = r;
    @(posedge clk);
    #1;
    v_b = 1'b0; d_b = 8'h00; rst_b = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        fe;
    logic        e_wr;
    logic [31:0] e_data;
    logic        e_busy;
    logic [7:0]  e_chk;
    logic [7:0]  e_fe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic fe,
                              input logic e_wr, input logic [31:0] e_data,
                              input logic e_busy, input logic [7:0] e_chk,
                              input logic [7:0] e_fe);
    vec_t r;
    r.v = v; r.d = d; r.fe = fe; r.e_wr = e_wr; r.e_data = e_data;
    r.e_busy = e_busy; r.e_chk = e_chk; r.e_fe = e_fe;
    return r;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fb[6];
    logic [7:0] cs;
    int gap, fe_pos, stall_pos;

    // Good frame: 11^22^33^44 = 44
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h22, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h33, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h44, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h44, 0, 1, 32'h11223344, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0));
    // Bad checksum 01
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h22, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h33, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h44, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0));
    // Next good frame written normally, back-to-back: DE^AD^BE^EF = 22
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 8'hDE, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 8'hAD, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 8'hBE, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 8'hEF, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 8'h22, 0, 1, 32'hDEADBEEF, 0, 1, 0));
    // Junk before sync, then frame error after two data bytes
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 8'h7F, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 8'h22, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1));
    // Sync value used as data: checksum A5
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 8'hA5, 0, 1, 32'hA5000000, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1));

    v_a = 0; d_a = 0; fe_a = 0; bt_a = 0; full_a = 0; rst_a = 1;
    v_b = 0; d_b = 0; fe_b = 0; bt_b = 0; full_b = 0; rst_b = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en_a", 32'(wr_a), 0);
    check("rst_wr_data_a", wd_a, 0);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_cnts_a", {chk_a, tmo_a, fec_a, drop_a}, 0);
    check("rst_wr_b", {15'h0, wr_b, wd_b}, 0);
    check("rst_busy_b", 32'(busy_b), 0);
    rst_a = 0; rst_b = 0;

    // Directed vector table
    for (int i = 0; i < tbl.size(); i++) begin
      apply_a(tbl[i].v, tbl[i].d, tbl[i].fe, 1'b0, 1'b0);
      check($sformatf("tbl%0d_wr_en", i), 32'(wr_a), 32'(tbl[i].e_wr));
      if (tbl[i].e_wr) check($sformatf("tbl%0d_wr_data", i), wd_a, tbl[i].e_data);
      check($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_chk", i), 32'(chk_a), 32'(tbl[i].e_chk));
      check($sformatf("tbl%0d_fe", i), 32'(fec_a), 32'(tbl[i].e_fe));
    end

    // Timeout after 20 idle ticks mid-frame
    apply_a(1, 8'hA5, 0, 0, 0);
    apply_a(1, 8'h11, 0, 0, 0);
    apply_a(1, 8'h22, 0, 0, 0);
    for (int t = 0; t < 19; t++) apply_a(0, 8'h00, 0, 1, 0);
    check("tmo_busy_19", 32'(busy_a), 1);
    check("tmo_cnt_19", 32'(tmo_a), 0);
    apply_a(0, 8'h00, 0, 1, 0);
    check("tmo_busy_20", 32'(busy_a), 0);
    check("tmo_cnt_20", 32'(tmo_a), 1);
    apply_a(1, 8'hA5, 0, 0, 0);
    apply_a(1, 8'h11, 0, 0, 0);
    apply_a(1, 8'h22, 0, 0, 0);
    apply_a(1, 8'h33, 0, 0, 0);
    apply_a(1, 8'h44, 0, 0, 0);
    apply_a(1, 8'h44, 0, 0, 0);
    check("tmo_next_wr", 32'(wr_a), 1);
    check("tmo_next_data", wd_a, 32'h11223344);

    // A byte arriving on the would-be timeout tick wins and restarts the timer
    apply_a(1, 8'hA5, 0, 0, 0);
    apply_a(1, 8'h11, 0, 0, 0);
    for (int t = 0; t < 19; t++) apply_a(0, 8'h00, 0, 1, 0);
    apply_a(1, 8'h22, 0, 1, 0);
    check("tmo_race_busy", 32'(busy_a), 1);
    check("tmo_race_cnt", 32'(tmo_a), 1);
    for (int t = 0; t < 19; t++) apply_a(0, 8'h00, 0, 1, 0);
    check("tmo_race_busy2", 32'(busy_a), 1);
    apply_a(1, 8'h33, 0, 0, 0);
    apply_a(1, 8'h44, 0, 0, 0);
    apply_a(1, 8'h44, 0, 0, 0);
    check("tmo_race_wr", 32'(wr_a), 1);
    check("tmo_race_data", wd_a, 32'h11223344);

    // Frame error beats a simultaneous byte
    apply_a(1, 8'hA5, 0, 0, 0);
    apply_a(1, 8'h11, 0, 0, 0);
    apply_a(1, 8'h22, 1, 0, 0);
    check("fe_race_busy", 32'(busy_a), 0);
    check("fe_race_cnt", 32'(fec_a), 2);
    check_model();

    // Random frames against the model
    for (int f = 0; f < 250; f++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        apply_a(($urandom_range(0, 5) == 0), 8'($urandom), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        check_model();
      end
      fb[0] = 8'hA5;
      cs = 8'h00;
      for (int k = 1; k < 5; k++) begin
        fb[k] = 8'($urandom);
        cs = cs ^ fb[k];
      end
      fb[5] = ($urandom_range(0, 4) == 0) ? (cs ^ 8'($urandom_range(1, 255))) : cs;
      fe_pos    = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 5) : 99;
      stall_pos = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : 99;
      for (int k = 0; k < 6; k++) begin
        if (k == stall_pos) begin
          for (int s = 0; s < 30; s++) begin
            apply_a(0, 8'h00, 0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
            check_model();
          end
        end
        if (k == fe_pos) apply_a(0, 8'h00, 1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        else             apply_a(1, fb[k], 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        check_model();
      end
    end

    // Drops with cmd_fifo_full: counter saturates at 255
    for (int f = 0; f < 300; f++) begin
      apply_a(1, 8'hA5, 0, 0, 1);
      apply_a(1, 8'h11, 0, 0, 1);
      apply_a(1, 8'h22, 0, 0, 1);
      apply_a(1, 8'h33, 0, 0, 1);
      apply_a(1, 8'h44, 0, 0, 1);
      apply_a(1, 8'h44, 0, 0, 1);
      if (f < 3 || f > 296) check($sformatf("drop%0d_wr_en", f), 32'(wr_a), 0);
    end
    check("drop_sat", 32'(drop_a), 255);
    check_model();

    // Reset mid-frame clears counters and discards the partial frame
    apply_a(1, 8'hA5, 0, 0, 0);
    apply_a(1, 8'h11, 0, 0, 0);
    rst_a = 1;
    @(posedge clk);
    model_reset();
    #1;
    rst_a = 0;
    check("mid_rst_busy", 32'(busy_a), 0);
    check("mid_rst_cnts", {chk_a, tmo_a, fec_a, drop_a}, 0);
    apply_a(1, 8'h22, 0, 0, 0); check_model();
    apply_a(1, 8'h33, 0, 0, 0); check_model();
    apply_a(1, 8'h44, 0, 0, 0); check_model();
    apply_a(1, 8'h44, 0, 0, 0); check_model();
    apply_a(0, 8'h00, 0, 0, 0); check_model();

    // Instance B: back-to-back 2-byte commands, then reset after one byte
    apply_b(1, 8'hDE, 0);
    check("b_busy_1", 32'(busy_b), 1);
    check("b_wr_1", 32'(wr_b), 0);
    apply_b(1, 8'hAD, 0);
    check("b_wr_2", 32'(wr_b), 1);
    check("b_data_2", 32'(wd_b), 32'h0000DEAD);
    check("b_busy_2", 32'(busy_b), 0);
    apply_b(1, 8'hBE, 0);
    check("b_wr_3", 32'(wr_b), 0);
    check("b_busy_3", 32'(busy_b), 1);
    apply_b(1, 8'hEF, 0);
    check("b_wr_4", 32'(wr_b), 1);
    check("b_data_4", 32'(wd_b), 32'h0000BEEF);
    apply_b(0, 8'h00, 0);
    check("b_wr_5", 32'(wr_b), 0);
    apply_b(1, 8'hDE, 0);
    check("b_busy_6", 32'(busy_b), 1);
    apply_b(0, 8'h00, 1);
    check("b_rst_busy", 32'(busy_b), 0);
    check("b_rst_wr", 32'(wr_b), 0);
    check("b_rst_cnts", {chk_b, tmo_b, fec_b, drop_b}, 0);
    apply_b(1, 8'hAD, 0);
    check("b_after_rst_wr", 32'(wr_b), 0);
    check("b_after_rst_busy", 32'(busy_b), 1);
    apply_b(0, 8'h00, 0);
    check("b_after_rst_wr2", 32'(wr_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
